// File: rtl/present_ksched.sv
// PRESENT key-schedule engine: loads one master key and streams NR round
// keys (forward for encrypt, reversed via inverse updates for decrypt).
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   ld_valid/ld_ready master-key load handshake (key_in, mode sampled)
//   mode              0 = K1..KNR, 1 = KNR..K1
//   key_in[0:KW-1]    master key, bit 0 = MSB
//   rk_valid/rk_ready round-key handshake
//   rk[0:63]          round key (key register bits 0..63)
//   rk_idx[0:4]       zero-based round number of rk
//   rk_last           final key of the sequence
//   busy              sequence in progress (PRE or EMIT)
module present_ksched #(
    parameter int KW = 80,
    parameter int NR = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic          mode,
    input  logic [0:KW-1] key_in,
    output logic          rk_valid,
    input  logic          rk_ready,
    output logic [0:63]   rk,
    output logic [0:4]    rk_idx,
    output logic          rk_last,
    output logic          busy
);

    if (!(KW == 80 || KW == 128)) begin : g_bad_kw
        $error("present_ksched: KW must be 80 or 128");
    end
    if (NR < 2 || NR > 32) begin : g_bad_nr
        $error("present_ksched: NR must be in 2..32");
    end

    // Start of the 5-bit round-counter field (k19..k15 or k66..k62).
    localparam int CP = (KW == 128) ? 61 : 60;
    localparam logic [4:0] LAST = 5'(NR - 1);
    localparam logic [4:0] PEND = 5'(NR - 2);

    localparam logic [63:0] SBOX  = 64'hC56B90AD3EF84712;
    localparam logic [63:0] ISBOX = 64'h5EF8C12DB463079A;

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        EMIT
    } state_t;

    state_t        state, state_n;
    logic [0:KW-1] key_q, key_n;
    logic [4:0]    idx_q, idx_n;
    logic          dec_q, dec_n;
    logic          vld_q, vld_n;
    logic          last_q, last_n;

    // Table entry for x sits at bits [(15-x)*4 +: 4]; 15-x == ~x.
    function automatic logic [3:0] sbox(input logic [3:0] x);
        return SBOX[{~x, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] isbox(input logic [3:0] x);
        return ISBOX[{~x, 2'b00} +: 4];
    endfunction

    function automatic logic [0:KW-1] fwd(input logic [0:KW-1] k,
                                          input logic [4:0]    c);
        logic [0:KW-1] t;
        t = {k[61:KW-1], k[0:60]};
        t[0:3] = sbox(t[0:3]);
        if (KW == 128) t[4:7] = sbox(t[4:7]);
        t[CP +: 5] = t[CP +: 5] ^ c;
        return t;
    endfunction

    function automatic logic [0:KW-1] inv(input logic [0:KW-1] k,
                                          input logic [4:0]    c);
        logic [0:KW-1] t;
        t = k;
        t[CP +: 5] = t[CP +: 5] ^ c;
        t[0:3] = isbox(t[0:3]);
        if (KW == 128) t[4:7] = isbox(t[4:7]);
        return {t[KW-61:KW-1], t[0:KW-62]};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            key_q  <= '0;
            idx_q  <= '0;
            dec_q  <= 1'b0;
            vld_q  <= 1'b0;
            last_q <= 1'b0;
        end else begin
            state  <= state_n;
            key_q  <= key_n;
            idx_q  <= idx_n;
            dec_q  <= dec_n;
            vld_q  <= vld_n;
            last_q <= last_n;
        end
    end

    // rk_valid/rk_last are computed one edge ahead so they leave as flops.
    always_comb begin
        state_n = state;
        key_n   = key_q;
        idx_n   = idx_q;
        dec_n   = dec_q;
        vld_n   = vld_q;
        last_n  = last_q;
        unique case (state)
            IDLE: begin
                if (ld_valid) begin
                    key_n = key_in;
                    dec_n = mode;
                    idx_n = '0;
                    if (mode) begin
                        state_n = PRE;
                    end else begin
                        state_n = EMIT;
                        vld_n   = 1'b1;
                        last_n  = 1'b0;
                    end
                end
            end
            PRE: begin
                // Roll forward to K_NR so decrypt can walk back down.
                key_n = fwd(key_q, idx_q + 5'd1);
                idx_n = idx_q + 5'd1;
                if (idx_q == PEND) begin
                    state_n = EMIT;
                    vld_n   = 1'b1;
                    last_n  = 1'b0;
                end
            end
            EMIT: begin
                if (rk_ready) begin
                    if (last_q) begin
                        state_n = IDLE;
                        vld_n   = 1'b0;
                        last_n  = 1'b0;
                    end else if (dec_q) begin
                        key_n  = inv(key_q, idx_q);
                        idx_n  = idx_q - 5'd1;
                        last_n = (idx_q == 5'd1);
                    end else begin
                        key_n  = fwd(key_q, idx_q + 5'd1);
                        idx_n  = idx_q + 5'd1;
                        last_n = (idx_q == PEND);
                    end
                end
            end
            default: begin
                state_n = IDLE;
                vld_n   = 1'b0;
                last_n  = 1'b0;
            end
        endcase
    end

    assign ld_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign rk_valid = vld_q;
    assign rk       = key_q[0:63];
    assign rk_idx   = idx_q;
    assign rk_last  = last_q;

endmodule

// File: tb/tb_present_ksched.sv
// Self-checking bench for present_ksched: three instances (80/32, 128/32,
// 80/2) checked against a plain-arithmetic PRESENT key-schedule model.
module tb_present_ksched;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         ld_valid[3];
    logic         mode[3];
    logic         rk_ready[3];
    logic [127:0] kin[3];
    logic         ld_ready[3];
    logic         rk_valid[3];
    logic         rk_last[3];
    logic         busy[3];
    logic [63:0]  rk[3];
    logic [4:0]   rk_idx[3];

    present_ksched #(.KW(80), .NR(32)) u0 (
        .clk(clk), .rst(rst), .ld_valid(ld_valid[0]), .ld_ready(ld_ready[0]),
        .mode(mode[0]), .key_in(kin[0][79:0]), .rk_valid(rk_valid[0]),
        .rk_ready(rk_ready[0]), .rk(rk[0]), .rk_idx(rk_idx[0]),
        .rk_last(rk_last[0]), .busy(busy[0]));

    present_ksched #(.KW(128), .NR(32)) u1 (
        .clk(clk), .rst(rst), .ld_valid(ld_valid[1]), .ld_ready(ld_ready[1]),
        .mode(mode[1]), .key_in(kin[1]), .rk_valid(rk_valid[1]),
        .rk_ready(rk_ready[1]), .rk(rk[1]), .rk_idx(rk_idx[1]),
        .rk_last(rk_last[1]), .busy(busy[1]));

    present_ksched #(.KW(80), .NR(2)) u2 (
        .clk(clk), .rst(rst), .ld_valid(ld_valid[2]), .ld_ready(ld_ready[2]),
        .mode(mode[2]), .key_in(kin[2][79:0]), .rk_valid(rk_valid[2]),
        .rk_ready(rk_ready[2]), .rk(rk[2]), .rk_idx(rk_idx[2]),
        .rk_last(rk_last[2]), .busy(busy[2]));

    function automatic int kwv(int d);
        return (d == 1) ? 128 : 80;
    endfunction

    function automatic int nrv(int d);
        return (d == 2) ? 2 : 32;
    endfunction

    logic [3:0] sb[16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                           4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    logic [63:0] mks[32];
    logic [63:0] exp_rk[3][32];
    int          exp_ix[3][32];
    int          lat[3];
    int          cnt[3];
    int          ldc[3];
    bit          active[3];
    bit          done[3];
    bit          seen[3];
    bit          stall[3];
    bit          post[3];
    logic [63:0] prk[3];
    logic [4:0]  pix[3];
    logic        plast[3];

    task automatic chk(string nm, logic [127:0] act, logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // PRESENT key schedule as numeric shifts; fills mks[0..nr-1]=K1..Knr.
    task automatic calc(int kw, int nr, logic [127:0] key);
        logic [127:0] k;
        logic [127:0] m;
        m = (kw == 128) ? '1 : ((128'd1 << 80) - 128'd1);
        k = key & m;
        for (int r = 1; r <= nr; r++) begin
            mks[r-1] = 64'(k >> (kw - 64));
            if (r < nr) begin
                k = ((k << 61) | (k >> (kw - 61))) & m;
                k[kw-1 -: 4] = sb[k[kw-1 -: 4]];
                if (kw == 128) k[kw-5 -: 4] = sb[k[kw-5 -: 4]];
                if (kw == 80) k[19:15] = k[19:15] ^ 5'(r);
                else k[66:62] = k[66:62] ^ 5'(r);
            end
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                active[d] = 0;
                stall[d] = 0;
                post[d] = 0;
                cnt[d] = 0;
                continue;
            end
            if (post[d]) begin
                chk("ld_ready_after_last", ld_ready[d], 1);
                chk("valid_after_last", rk_valid[d], 0);
                post[d] = 0;
            end
            if (ld_valid[d] && ld_ready[d]) begin
                active[d] = 1;
                cnt[d] = 0;
                ldc[d] = cyc;
                seen[d] = 0;
                stall[d] = 0;
            end else if (active[d]) begin
                chk("ld_ready_busy", ld_ready[d], 0);
                chk("busy", busy[d], 1);
            end
            if (rk_valid[d]) begin
                if (!active[d]) begin
                    chk("extra_key", rk_valid[d], 0);
                end else begin
                    if (!seen[d]) begin
                        chk("latency", cyc - ldc[d], lat[d]);
                        seen[d] = 1;
                    end
                    if (stall[d]) begin
                        chk("stall_rk", rk[d], prk[d]);
                        chk("stall_idx", rk_idx[d], pix[d]);
                        chk("stall_last", rk_last[d], plast[d]);
                    end
                    if (rk_ready[d]) begin
                        chk("rk", rk[d], exp_rk[d][cnt[d]]);
                        chk("rk_idx", rk_idx[d], exp_ix[d][cnt[d]]);
                        chk("rk_last", rk_last[d], cnt[d] == nrv(d) - 1);
                        cnt[d]++;
                        stall[d] = 0;
                        if (cnt[d] == nrv(d)) begin
                            active[d] = 0;
                            done[d] = 1;
                            post[d] = 1;
                        end
                    end else begin
                        stall[d] = 1;
                        prk[d] = rk[d];
                        pix[d] = rk_idx[d];
                        plast[d] = rk_last[d];
                    end
                end
            end
        end
    end

    task automatic load(int d, bit md, logic [127:0] key);
        int nr;
        nr = nrv(d);
        calc(kwv(d), nr, key);
        for (int i = 0; i < nr; i++) begin
            exp_rk[d][i] = md ? mks[nr-1-i] : mks[i];
            exp_ix[d][i] = md ? nr - 1 - i : i;
        end
        lat[d] = md ? nr : 1;
        done[d] = 0;
        ld_valid[d] = 1;
        mode[d] = md;
        kin[d] = key;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(int d, bit hold, bit bp);
        if (!hold) ld_valid[d] = 0;
        for (int t = 0; t < 1000 && !done[d]; t++) begin
            rk_ready[d] = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (hold) begin
                kin[d] = {$urandom, $urandom, $urandom, $urandom};
                mode[d] = ~mode[d];
            end
            if (cnt[d] >= nrv(d) - 1) ld_valid[d] = 0;
            @(posedge clk);
            #1;
        end
        chk("timeout", done[d], 1);
        ld_valid[d] = 0;
        rk_ready[d] = 0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic run(int d, bit md, logic [127:0] key, bit hold, bit bp);
        load(d, md, key);
        drain(d, hold, bp);
    endtask

    logic [127:0] rkey;

    initial begin
        for (int d = 0; d < 3; d++) begin
            ld_valid[d] = 0;
            mode[d] = 0;
            rk_ready[d] = 0;
            kin[d] = '0;
            done[d] = 0;
            cnt[d] = 0;
            lat[d] = 1;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        for (int d = 0; d < 3; d++) begin
            chk("rst_ld_ready", ld_ready[d], 1);
            chk("rst_rk_valid", rk_valid[d], 0);
            chk("rst_rk", rk[d], 0);
            chk("rst_rk_idx", rk_idx[d], 0);
            chk("rst_rk_last", rk_last[d], 0);
            chk("rst_busy", busy[d], 0);
        end

        calc(80, 32, 128'd0);
        chk("pin80_k1", mks[0], 64'h0000000000000000);
        chk("pin80_k2", mks[1], 64'hC000000000000000);
        chk("pin80_k3", mks[2], 64'h5000180000000001);
        calc(128, 32, '1);
        chk("pin128_k1", mks[0], 64'hFFFFFFFFFFFFFFFF);
        chk("pin128_k2", mks[1], 64'h22FFFFFFFFFFFFFF);

        run(0, 0, 128'd0, 0, 0);
        run(0, 1, 128'd0, 0, 0);
        run(0, 0, 128'h0123456789ABCDEF0123, 0, 1);
        run(0, 1, 128'h0123456789ABCDEF0123, 0, 1);

        run(1, 0, '1, 0, 0);
        run(1, 1, '1, 0, 0);
        run(1, 1, '1, 0, 1);

        run(0, 0, 128'h0123456789ABCDEF0123, 1, 1);
        run(0, 1, 128'h0123456789ABCDEF0123, 1, 1);

        load(0, 0, 128'd0);
        ld_valid[0] = 0;
        rk_ready[0] = 1;
        for (int t = 0; t < 100; t++) begin
            if (rk_valid[0] && rk_idx[0] == 5'd10) break;
            @(posedge clk);
            #1;
        end
        chk("reach_idx10", rk_idx[0], 10);
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        chk("abort_valid", rk_valid[0], 0);
        chk("abort_ld_ready", ld_ready[0], 1);
        chk("abort_busy", busy[0], 0);
        rk_ready[0] = 0;
        run(0, 0, 128'h0123456789ABCDEF0123, 0, 0);

        run(2, 0, 128'h0123456789ABCDEF0123, 0, 0);
        run(2, 1, 128'h0123456789ABCDEF0123, 0, 0);
        run(2, 1, 128'h0123456789ABCDEF0123, 1, 1);

        for (int i = 0; i < 6; i++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom};
            run(i % 3, 1'($urandom_range(0, 1)), rkey, 0, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
